// File: rtl/mult_pkg.sv
// Shared types and constants for the 8x8 shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH      = 8;
    localparam int ITERATIONS = 8;
    localparam int PRODUCT_W  = 16;

endpackage

// File: rtl/full_adder_eight_bit.sv
// Ripple-carry adder built from one full-adder cell per bit.
module full_adder_eight_bit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier_eight_bit.sv
// Sequential 8x8 unsigned multiplier: one conditional add and right shift per cycle,
// eight iterations, with a start/busy/done handshake.
module shift_add_multiplier_eight_bit
    import mult_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ITER_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           a,
    input  logic [7:0]           b,
    output logic                 busy,
    output logic                 done,
    output logic [PRODUCT_W-1:0] product
);

    state_t            state_reg, state_next;
    logic [ITER_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0]  mcand_reg, mcand_next;
    logic [WIDTH-1:0]  acc_hi_reg, acc_hi_next;
    logic [WIDTH-1:0]  acc_lo_reg, acc_lo_next;

    logic [WIDTH-1:0]  add_b;
    logic [WIDTH-1:0]  add_sum;
    logic              add_cout;

    // Zeroing the addend when the multiplier LSB is clear makes the adder pass acc_hi through.
    assign add_b = acc_lo_reg[0] ? mcand_reg : '0;

    full_adder_eight_bit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (acc_hi_reg),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            mcand_reg  <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            mcand_reg  <= mcand_next;
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        mcand_next  = mcand_reg;
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    mcand_next  = a;
                    acc_hi_next = '0;
                    acc_lo_next = b;
                    count_next  = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                // The adder carry becomes the new MSB so no product bit is lost.
                acc_hi_next = {add_cout, add_sum[WIDTH-1:1]};
                acc_lo_next = {add_sum[0], acc_lo_reg[WIDTH-1:1]};
                count_next  = count_reg + ITER_W'(1);
                if (count_reg == ITER_W'(ITERATIONS - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign product = {acc_hi_reg, acc_lo_reg};

endmodule

// File: tb/tb_shift_add_multiplier_eight_bit.sv
// Directed-vector bench for the shift-and-add multiplier with immediate-assertion checks.
module tb_shift_add_multiplier_eight_bit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int vectors;
    int miscompares;
    int done_pulses;

    shift_add_multiplier_eight_bit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_pulses++;
    end

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Waits up to 20 cycles for done; returns the number of negedges it took (21 on timeout).
    task automatic wait_done(output int cycles);
        cycles = 21;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Presents one start request, then checks latency, product and the return to idle.
    task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic [15:0] expected);
        int cycles;
        @(negedge clk);
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, {15'd0, busy}, 16'd1);
        wait_done(cycles);
        check({tag, "_latency"}, 16'(cycles), 16'd8);
        check({tag, "_product"}, product, expected);
        @(negedge clk);
        check({tag, "_busy_cleared"}, {15'd0, busy}, 16'd0);
        check({tag, "_done_cleared"}, {15'd0, done}, 16'd0);
    endtask

    initial begin
        int cycles;
        int pulses_before;
        vectors     = 0;
        miscompares = 0;
        done_pulses = 0;
        reset = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;

        #1;
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_done", {15'd0, done}, 16'd0);
        check("reset_product", product, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op("d_x_b", 8'h0D, 8'h0B, 16'h008F);
        run_op("ff_x_ff", 8'hFF, 8'hFF, 16'hFE01);
        run_op("ff_x_01", 8'hFF, 8'h01, 16'h00FF);
        run_op("80_x_02", 8'h80, 8'h02, 16'h0100);
        run_op("00_x_a5", 8'h00, 8'hA5, 16'h0000);
        run_op("01_x_00", 8'h01, 8'h00, 16'h0000);

        // Start held high across RUN and DONE: only re-accepted once back in IDLE.
        pulses_before = done_pulses;
        @(negedge clk);
        start = 1'b1;
        a     = 8'h03;
        b     = 8'h05;
        @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        wait_done(cycles);
        check("hold_first_latency", 16'(cycles), 16'd8);
        check("hold_first_product", product, 16'h000F);
        @(negedge clk);
        check("hold_idle_gap_busy", {15'd0, busy}, 16'd0);
        check("hold_idle_gap_product", product, 16'h000F);
        @(negedge clk);
        start = 1'b0;
        check("hold_second_busy", {15'd0, busy}, 16'd1);
        wait_done(cycles);
        check("hold_second_latency", 16'(cycles), 16'd8);
        check("hold_second_product", product, 16'hFE01);
        @(negedge clk);
        check("hold_done_pulses", 16'(done_pulses - pulses_before), 16'd2);

        // Asynchronous reset in the middle of iteration 4.
        pulses_before = done_pulses;
        @(negedge clk);
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_done", {15'd0, done}, 16'd0);
        check("abort_product", product, 16'h0000);
        repeat (12) @(negedge clk);
        check("abort_no_done", 16'(done_pulses - pulses_before), 16'd0);
        reset = 1'b0;
        run_op("12_x_34", 8'h12, 8'h34, 16'h03A8);

        // Product must hold while inputs wander with start low.
        run_op("07_x_09", 8'h07, 8'h09, 16'h003F);
        pulses_before = done_pulses;
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
            check("hold_product", product, 16'h003F);
            check("hold_done", {15'd0, done}, 16'd0);
        end
        check("hold_no_pulse", 16'(done_pulses - pulses_before), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
